// File: rtl/fpencoder_seq_if.sv
// Handshake and operand/result bus of the multicycle IEEE-754 single-precision packer.
interface fpencoder_seq_if #(
    parameter int unsigned MANT_W = 48
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [9:0]        in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_inf;
    logic              in_nan;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [3:0]        out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_inf, in_nan, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_inf, in_nan, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpencoder_seq.sv
// Multicycle single-precision packer: bit-serial normalize, round-to-nearest-even, pack + flags.
// Optional gradual underflow (subnormal results) enabled by defining FPENC_DENORM_EN.
module fpencoder_seq #(
    parameter int unsigned MANT_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    fpencoder_seq_if.slave   bus
);
    localparam int unsigned EXP_W  = 12;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned HID    = MANT_W - 2;
    localparam int unsigned CAR    = MANT_W - 1;
    localparam logic [MANT_W-1:0] LOW_MASK = (MANT_W'(1) << (MANT_W - 26)) - MANT_W'(1);
    localparam logic signed [EXP_W-1:0] EMIN = -12'sd126;
    localparam logic signed [EXP_W-1:0] EMAX = 12'sd127;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                    state;
    logic signed [EXP_W-1:0]   exp_q;
    logic [MANT_W-1:0]         mant_q;
    logic                      sticky_q;
    logic                      sign_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [31:0]               result_q;
    logic [3:0]                flags_q;

    // Rounding datapath, evaluated from the normalized mantissa held in ROUND
    logic [FRAC_W-1:0]         frac_c;
    logic                      guard_c;
    logic                      sticky_all_c;
    logic                      inc_c;
    logic                      inexact_c;
    logic [FRAC_W:0]           frac_sum_c;
    logic                      frac_carry_c;
    logic [FRAC_W-1:0]         frac_rnd_c;
    logic signed [EXP_W-1:0]   exp_rnd_c;
    logic [7:0]                biased_c;
`ifdef FPENC_DENORM_EN
    logic                      hid_rnd_c;
`endif

    always_comb begin
        frac_c       = mant_q[MANT_W-3 -: FRAC_W];
        guard_c      = mant_q[MANT_W-26];
        sticky_all_c = sticky_q | (|(mant_q & LOW_MASK));
        inc_c        = guard_c & (sticky_all_c | frac_c[0]);
        inexact_c    = guard_c | sticky_all_c;
        frac_sum_c   = {1'b0, frac_c} + (FRAC_W+1)'(inc_c);
        frac_carry_c = frac_sum_c[FRAC_W];
        frac_rnd_c   = frac_sum_c[FRAC_W-1:0];
`ifdef FPENC_DENORM_EN
        // A subnormal carry lands in the hidden bit instead of bumping the exponent
        hid_rnd_c    = mant_q[HID] | frac_carry_c;
        exp_rnd_c    = exp_q + EXP_W'(frac_carry_c & mant_q[HID]);
`else
        exp_rnd_c    = exp_q + EXP_W'(frac_carry_c);
`endif
        biased_c     = 8'(exp_rnd_c + 12'sd127);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            exp_q       <= '0;
            mant_q      <= '0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (bus.in_nan) begin
                            result_q    <= 32'h7FC0_0000;
                            flags_q     <= 4'b0000;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else if (bus.in_inf) begin
                            result_q    <= {bus.in_sign, 8'hFF, 23'd0};
                            flags_q     <= 4'b0000;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else if (bus.in_mant == '0) begin
                            result_q    <= {bus.in_sign, 31'd0};
                            flags_q     <= 4'b0001;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            sign_q   <= bus.in_sign;
                            exp_q    <= {{2{bus.in_exp[9]}}, bus.in_exp};
                            mant_q   <= bus.in_mant;
                            sticky_q <= 1'b0;
                            state    <= NORM;
                        end
                    end
                end
                NORM: begin
`ifdef FPENC_DENORM_EN
                    if (exp_q < EMIN) begin
                        mant_q   <= mant_q >> 1;
                        sticky_q <= sticky_q | mant_q[0];
                        exp_q    <= exp_q + 12'sd1;
                    end else if (mant_q[CAR]) begin
                        mant_q   <= mant_q >> 1;
                        sticky_q <= sticky_q | mant_q[0];
                        exp_q    <= exp_q + 12'sd1;
                        state    <= ROUND;
                    end else if (mant_q[HID] || exp_q == EMIN) begin
                        state <= ROUND;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - 12'sd1;
                    end
`else
                    if (mant_q[CAR]) begin
                        mant_q   <= mant_q >> 1;
                        sticky_q <= sticky_q | mant_q[0];
                        exp_q    <= exp_q + 12'sd1;
                        state    <= ROUND;
                    end else if (mant_q[HID] || exp_q < EMIN) begin
                        state <= ROUND;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - 12'sd1;
                    end
`endif
                end
                ROUND: begin
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                    if (exp_rnd_c > EMAX) begin
                        result_q <= {sign_q, 8'hFF, 23'd0};
                        flags_q  <= 4'b1010;
`ifdef FPENC_DENORM_EN
                    end else begin
                        result_q <= {sign_q, hid_rnd_c ? biased_c : 8'h00, frac_rnd_c};
                        flags_q  <= {1'b0, ~hid_rnd_c & inexact_c, inexact_c,
                                     ~hid_rnd_c & (frac_rnd_c == '0)};
                    end
`else
                    end else if (exp_rnd_c < EMIN) begin
                        result_q <= {sign_q, 31'd0};
                        flags_q  <= 4'b0111;
                    end else begin
                        result_q <= {sign_q, biased_c, frac_rnd_c};
                        flags_q  <= {2'b00, inexact_c, 1'b0};
                    end
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_flags  = flags_q;
endmodule

// File: doc/fpencoder_seq.md
Name: fpencoder_seq

Overview:
- Multicycle IEEE-754 single-precision packer; the inverse of the field decoder.
- Accepts sign, unbiased exponent and an unnormalized fixed-point mantissa from the FP datapath (adder or multiplier result).
- Normalizes one bit per cycle, rounds to nearest-even and packs a 32-bit word with status flags.
- Sits between the FP execute stage and the register-file writeback in the multicycle core.

Parameters:
- MANT_W, 48, input mantissa width. Value is in_mant / 2^(MANT_W-2). Bit MANT_W-1 is the carry bit; bit MANT_W-2 is the hidden bit. MANT_W must be at least 26.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operand present
- in_ready  out  1  block idle; operand accepted when in_valid && in_ready
- in_sign  in  1  sign
- in_exp  in  10  signed unbiased exponent
- in_mant  in  MANT_W  unsigned mantissa
- in_inf  in  1  force infinity
- in_nan  in  1  force NaN; has priority over in_inf
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  32  packed {sign, biased exponent[7:0], fraction[22:0]}
- out_flags  out  4  {overflow, underflow, inexact, zero}

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_result=0, out_flags=0, FSM=IDLE. Reset overrides any state, including mid-NORM and DONE; in_ready reads 1 the cycle after reset deasserts.
- Internal state: exponent register is 12-bit signed; mantissa register is MANT_W bits; sticky register is 1 bit.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On accept with in_nan: go to DONE; result 0x7FC00000, flags 0.
  - On accept with in_inf: go to DONE; result {sign, 0xFF, 0}, flags 0.
  - On accept with in_mant==0: go to DONE; result {sign, 31'b0}, zero=1.
  - Otherwise latch operands, clear sticky, go to NORM.
- NORM (in_ready=0):
  - If mant[MANT_W-1]: shift right 1, OR the shifted-out bit into sticky, exp+1, go to ROUND.
  - Else if mant[MANT_W-2]: go to ROUND.
  - Else if exp < -126: go to ROUND (underflow path; no further shifting).
  - Else: shift left 1, exp-1, stay in NORM.
- ROUND:
  - Fields: frac = mant[MANT_W-3 : MANT_W-25]; guard = mant[MANT_W-26]; sticky_all = sticky | OR(mant[MANT_W-27:0]).
  - Round-to-nearest-even: increment frac when guard && (sticky_all || frac[0]).
  - inexact = guard | sticky_all.
  - If frac carries out, set frac=0 and exp+1.
  - Classify the post-round exponent:
    - exp > 127: result {sign, 0xFF, 0}; overflow=1, inexact=1.
    - exp < -126: result {sign, 31'b0}; underflow=1, zero=1, inexact=1.
    - Otherwise: result {sign, exp+127, frac}.
  - Go to DONE.
- DONE:
  - out_valid=1.
  - out_result and out_flags stay stable while !out_ready.
  - On out_ready: go to IDLE; out_valid drops next cycle; out_result keeps its last value.
  - in_ready=0 throughout DONE; no new operand can be accepted the same cycle a result is taken.
- Latency (accept edge = cycle t):
  - Special inputs and zero mantissa: out_valid at t+1.
  - Normalized input or carry input: out_valid at t+3.
  - Each left shift adds 1 cycle.
  - Worst case is bounded by MANT_W-2 shifts or the underflow stop.
- in_valid while busy is ignored and not queued.
- Sign is preserved on zero, infinity and overflow results.

Optional Feature:
- Macro: FPENC_DENORM_EN.
- Defined:
  - NORM stops left-shifting once exp == -126.
  - If exp < -126 with a nonzero mantissa, NORM right-shifts (sticky accumulated, exp+1) until exp == -126.
  - ROUND then packs biased exponent 0 when the hidden bit is 0 (subnormal).
  - Rounding may carry into the hidden bit, giving biased exponent 1.
  - underflow=1 only if the result is inexact.
  - zero=1 only if frac==0 after rounding.
- Undefined: flush-to-zero as described in Behaviour.

Test Plan:
- Normalized input: mant=48'h400000000000, exp=0, sign=0 -> out_result=0x3F800000, flags=0, out_valid at t+3.
- Carry input and left-shift input:
  - mant=48'hC00000000000, exp=0 -> 0x40400000 at t+3.
  - mant=48'h100000000000, exp=0 -> 0x3E800000 at t+5.
- Rounding:
  - mant=48'h400000400000 (tie, lsb 0) -> 0x3F800000, inexact=1.
  - mant=48'h400000C00000 (tie, lsb 1) -> 0x3F800002, inexact=1.
- Range limits:
  - exp=128, mant=1.0 -> 0x7F800000, overflow=1.
  - sign=1, exp=-127, mant=1.0 -> 0x80000000, underflow=1, zero=1 (macro off).
  - Same input with macro on -> 0x80400000, flags=0.
- Specials and zero:
  - in_nan=1 -> 0x7FC00000 at t+1.
  - in_mant=0, sign=1 -> 0x80000000, zero=1 at t+1.
- Handshake and reset:
  - out_ready=0 for 4 cycles -> out_valid, out_result and out_flags stable; in_ready=0; in_valid pulses ignored.
  - reset asserted during NORM -> out_valid=0, in_ready=1 the cycle after reset drops.
